seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_pkg.sv | 33 +++
 rtl/mul_addshift_step.sv | 34 +++
 rtl/seq_multiplier.sv | 131 +++++++++++++
 tb/tb_seq_multiplier.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
//   Shared types and helpers for the sequential shift-add multiplier.
//   - state_t      : controller states (IDLE, BUSY, DONE)
//   - OP_BITS      : working width of the negate helper (covers 2*32 bits)
//   - cnt_width()  : step-counter width for a given operand width
//   - cond_negate(): conditional two's-complement negate, used both for
//                    operand magnitude (abs) and for the final sign fix
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned OP_BITS   = 2 * MAX_WIDTH;

  // Counter must reach WIDTH-1; $clog2(WIDTH) bits suffice for WIDTH >= 2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Callers zero-extend into OP_BITS and slice the result back down, so a
  // WIDTH-bit -2^(WIDTH-1) yields the unsigned magnitude 2^(WIDTH-1).
  function automatic logic [OP_BITS-1:0] cond_negate(input logic [OP_BITS-1:0] v,
                                                     input logic               en);
    return en ? (~v + OP_BITS'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_addshift_step.sv
// -----------------------------------------------------------------------------
// mul_addshift_step
//   One combinational add-and-shift step of a shift-add multiplier.
//   The accumulator upper half holds the running partial product; the lower
//   half holds the not-yet-consumed multiplier bits. When lsb is set the
//   multiplicand is added into the upper half (keeping the carry), then the
//   whole {carry, accumulator} is shifted right by one.
//
//   Ports:
//     acc      in   2*WIDTH  current accumulator
//     mcand    in   WIDTH    multiplicand (unsigned magnitude)
//     lsb      in   1        current multiplier bit
//     acc_next out  2*WIDTH  accumulator after this step
// -----------------------------------------------------------------------------
module mul_addshift_step
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               lsb,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (lsb ? {1'b0, mcand} : '0);
    // The carry lands in bit 2*WIDTH-1 after the shift, so no bit is lost.
    acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Parametrised sequential shift-add multiplier, one product bit per clock,
//   one operation in flight. valid/ready handshake on input and output.
//   SIGNED=1 multiplies magnitudes and applies a two's-complement fix at the
//   final step.
//
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     in_valid   in   1        operands a/b valid
//     in_ready   out  1        ready for operands (IDLE only)
//     a          in   WIDTH    multiplicand
//     b          in   WIDTH    multiplier
//     out_valid  out  1        product valid (DONE)
//     out_ready  in   1        downstream accepts product
//     product    out  2*WIDTH  result, held until the next result
//     busy       out  1        high in BUSY or DONE
//
//   Timing: accept on edge E0, out_valid high after edge E0+WIDTH.
//   All handshake outputs are registered; no input-to-output comb path.
// -----------------------------------------------------------------------------
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mcand;
  logic             neg;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    result;

  // Operand magnitudes; in unsigned mode the operands pass through untouched.
  always_comb begin
    sign_a = SIGNED ? a[WIDTH-1] : 1'b0;
    sign_b = SIGNED ? b[WIDTH-1] : 1'b0;
    mag_a  = WIDTH'(cond_negate(OP_BITS'(a), sign_a));
    mag_b  = WIDTH'(cond_negate(OP_BITS'(b), sign_b));
    // Negating zero gives zero, so a zero product never picks up a sign.
    result = PW'(cond_negate(OP_BITS'(acc_next), neg));
  end

  mul_addshift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .lsb      (acc[0]),
    .acc_next (acc_next)
  );

  // The multiplier magnitude is parked in the lower half of the accumulator
  // (upper half cleared); each step consumes one bit from the bottom while the
  // partial product grows in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= mag_a;
            acc      <= {{WIDTH{1'b0}}, mag_b};
            neg      <= sign_a ^ sign_b;
            count    <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            product   <= result;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Six instances: WIDTH 8/4/16, each unsigned and signed. Directed steps
//   followed by random operations against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [15:0]       a_bus;
  logic [15:0]       b_bus;
  logic [N-1:0]      iv;
  logic [N-1:0]      orr;
  logic [N-1:0]      ir;
  logic [N-1:0]      ov;
  logic [N-1:0]      bz;
  logic [N-1:0][31:0] prod;

  int total = 0;
  int bad   = 0;

  function automatic int unsigned wd(input int idx);
    return (idx < 2) ? 8 : (idx < 4) ? 4 : 16;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned W = (g < 2) ? 8 : (g < 4) ? 4 : 16;
    localparam bit          S = ((g % 2) == 1);
    logic [2*W-1:0] p;
    seq_multiplier #(
      .WIDTH  (W),
      .SIGNED (S)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (a_bus[W-1:0]),
      .b         (b_bus[W-1:0]),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .product   (p),
      .busy      (bz[g])
    );
    assign prod[g] = 32'(p);
  end

  // Reference: interpret operands per width/sign, multiply, keep 2*W bits.
  function automatic logic [31:0] ref_mul(input int idx, input logic [15:0] x,
                                          input logic [15:0] y);
    int unsigned w = wd(idx);
    bit          s = (idx % 2) == 1;
    longint      one = 1;
    longint      mask = (one << w) - 1;
    longint      xv = longint'(x) & mask;
    longint      yv = longint'(y) & mask;
    longint      r;
    if (s && xv[w-1]) xv = xv - (one << w);
    if (s && yv[w-1]) yv = yv - (one << w);
    r = (xv * yv) & ((one << (2 * w)) - 1);
    return 32'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full transaction on instance idx; stall > 0 holds out_ready low for
  // that many DONE cycles while presenting junk operands that must be ignored.
  task automatic do_op(input int idx, input logic [15:0] x, input logic [15:0] y,
                       input int stall);
    int n;
    int lat;
    int irh;
    logic [31:0] expv;
    logic [31:0] held;
    expv     = ref_mul(idx, x, y);
    orr[idx] = (stall == 0);
    a_bus    = x;
    b_bus    = y;
    iv[idx]  = 1'b1;
    n = 0;
    while (!ir[idx] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 64), 32'd1);
    @(negedge clk);
    iv[idx] = 1'b0;
    lat = 0;
    irh = 0;
    while (!ov[idx] && lat < 200) begin
      if (ir[idx]) irh++;
      @(negedge clk);
      lat++;
    end
    if (ir[idx]) irh++;
    chk("latency", 32'(lat), 32'(wd(idx)));
    chk("in_ready_low", 32'(irh), 32'd0);
    chk("busy_done", 32'(bz[idx]), 32'd1);
    chk("product", prod[idx], expv);
    if (stall > 0) begin
      held    = prod[idx];
      a_bus   = ~x;
      b_bus   = ~y;
      iv[idx] = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_valid", 32'(ov[idx]), 32'd1);
        chk("stall_hold", prod[idx], held);
        chk("stall_ready", 32'(ir[idx]), 32'd0);
      end
      orr[idx] = 1'b1;
    end
    @(negedge clk);
    chk("one_valid", 32'(ov[idx]), 32'd0);
    chk("idle_ready", 32'(ir[idx]), 32'd1);
    chk("no_accept", 32'(bz[idx]), 32'd0);
    chk("idle_hold", prod[idx], expv);
    iv[idx] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int ovh;
    int st;
    logic [15:0] x;
    logic [15:0] y;
    rst_n = 1'b0;
    iv    = '0;
    orr   = '1;
    a_bus = '0;
    b_bus = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready", 32'(ir[i]), 32'd1);
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_busy", 32'(bz[i]), 32'd0);
      chk("rst_product", prod[i], 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed unsigned / signed cases
    do_op(0, 16'd13, 16'd11, 0);
    do_op(0, 16'd255, 16'd255, 0);
    do_op(0, 16'd0, 16'd200, 0);
    do_op(1, 16'h00FD, 16'd5, 0);
    do_op(1, 16'h0080, 16'h0080, 0);
    do_op(1, 16'h0080, 16'd1, 0);

    // Backpressure for 5 cycles in DONE
    do_op(0, 16'd13, 16'd11, 5);

    // Reset while BUSY at count == 3
    a_bus = 16'd100;
    b_bus = 16'd3;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(bz[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov[0]), 32'd0);
    chk("arst_in_ready", 32'(ir[0]), 32'd1);
    chk("arst_product", prod[0], 32'd0);
    chk("arst_busy", 32'(bz[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ovh = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[0]) ovh++;
    end
    chk("no_valid_after_rst", 32'(ovh), 32'd0);
    do_op(0, 16'd7, 16'd6, 0);

    // Random back-to-back traffic with corners on every instance
    for (int idx = 0; idx < N; idx++) begin
      for (int k = 0; k < 16; k++) begin
        x = 16'($urandom);
        y = 16'($urandom);
        if (k == 0) begin
          x = 16'd1 << (wd(idx) - 1);
          y = x;
        end else if (k == 1) begin
          x = '0;
        end else if (k == 2) begin
          x = 16'd1 << (wd(idx) - 1);
          y = 16'd1;
        end
        st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        do_op(idx, x, y, st);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
